// File: rtl/fpu_ss_core_arbiter.sv
// Purpose: shares one FPU between NB_CORES cores (round-robin issue and result routing by dest core ID).
// Latency: issue and result paths are zero-cycle combinational; err_o is registered one cycle after a drop.
// Backpressure: a stalled issue locks the grant until handshake; per-core outstanding counters gate eligibility.
module fpu_ss_core_arbiter #(
    parameter int NB_CORES  = 8,
    parameter int PAYLOAD_W = 64,
    parameter int RES_W     = 64,
    parameter int MAX_OUTST = 4
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    // core side
    input  logic [NB_CORES-1:0]           core_issue_valid_i,
    output logic [NB_CORES-1:0]           core_issue_ready_o,
    input  logic [NB_CORES*PAYLOAD_W-1:0] core_issue_payload_i,
    output logic [NB_CORES-1:0]           core_result_valid_o,
    input  logic [NB_CORES-1:0]           core_result_ready_i,
    output logic [RES_W-1:0]              core_result_o,
    // FPU side
    output logic                          fpu_issue_valid_o,
    input  logic                          fpu_issue_ready_i,
    output logic [PAYLOAD_W-1:0]          fpu_issue_payload_o,
    output logic [31:0]                   fpu_core_id_o,
    input  logic                          fpu_result_valid_i,
    output logic                          fpu_result_ready_o,
    input  logic [RES_W-1:0]              fpu_result_i,
    input  logic [31:0]                   fpu_dest_core_id_i,
    // status
    output logic                          err_o
);

    localparam int IDX_W = $clog2(NB_CORES);
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTST);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_CORES - 1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    state_t           r_state;
    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] r_lock_idx;
    logic [CNT_W-1:0] r_outst [NB_CORES];
    logic             r_err;

    logic [NB_CORES-1:0] w_elig;
    logic                w_rr_found;
    logic [IDX_W-1:0]    w_rr_idx;
    logic [IDX_W-1:0]    w_gnt_idx;
    logic                w_issue_vld;
    logic                w_iss_hs;
    logic                w_dest_in_range;
    logic [IDX_W-1:0]    w_dest_idx;
    logic                w_res_ok;
    logic                w_res_hs;
    logic                w_drop;

    // (base + off) modulo NB_CORES, off is always below NB_CORES
    function automatic logic [IDX_W-1:0] f_wrap_add(input logic [IDX_W-1:0] base, input int off);
        int sum;
        sum = int'(base) + off;
        if (sum >= NB_CORES) begin
            sum = sum - NB_CORES;
        end
        return IDX_W'(sum);
    endfunction

    // a core may compete only while it still has in-flight headroom
    always_comb begin
        w_elig = '0;
        for (int c = 0; c < NB_CORES; c++) begin
            w_elig[c] = core_issue_valid_i[c] && (r_outst[c] < MAX_CNT);
        end
    end

    // round-robin search: scan downward so the closest eligible core to rr_ptr wins last
    always_comb begin
        w_rr_found = 1'b0;
        w_rr_idx   = '0;
        for (int k = NB_CORES - 1; k >= 0; k--) begin
            if (w_elig[f_wrap_add(r_rr_ptr, k)]) begin
                w_rr_found = 1'b1;
                w_rr_idx   = f_wrap_add(r_rr_ptr, k);
            end
        end
    end

    // a locked grant never depends on fpu_issue_ready_i, keeping valid/payload stable
    assign w_gnt_idx           = (r_state == ST_LOCKED) ? r_lock_idx : w_rr_idx;
    assign w_issue_vld         = (r_state == ST_LOCKED) || w_rr_found;
    assign w_iss_hs            = w_issue_vld && fpu_issue_ready_i;
    assign fpu_issue_valid_o   = w_issue_vld;
    assign fpu_issue_payload_o = core_issue_payload_i[w_gnt_idx*PAYLOAD_W +: PAYLOAD_W];
    assign fpu_core_id_o       = 32'(w_gnt_idx);

    // only the granted core sees the FPU's ready
    always_comb begin
        core_issue_ready_o = '0;
        if (w_issue_vld) begin
            core_issue_ready_o[w_gnt_idx] = fpu_issue_ready_i;
        end
    end

    // a result is routable only to an existing core that is actually waiting for one
    assign w_dest_in_range = fpu_dest_core_id_i < 32'(NB_CORES);
    assign w_dest_idx      = fpu_dest_core_id_i[IDX_W-1:0];
    assign w_res_ok        = w_dest_in_range && (r_outst[w_dest_idx] != '0);
    assign w_res_hs        = fpu_result_valid_i && w_res_ok && core_result_ready_i[w_dest_idx];
    assign w_drop          = fpu_result_valid_i && !w_res_ok;

    // unroutable results are swallowed (ready follows valid) so the FPU never stalls on them
    assign fpu_result_ready_o = w_res_ok ? core_result_ready_i[w_dest_idx] : fpu_result_valid_i;
    assign core_result_o      = fpu_result_i;
    assign err_o              = r_err;

    // one-hot result valid toward the destination core
    always_comb begin
        core_result_valid_o = '0;
        if (w_res_ok) begin
            core_result_valid_o[w_dest_idx] = fpu_result_valid_i;
        end
    end

    // issue FSM, round-robin pointer and drop flag
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= '0;
            r_lock_idx <= '0;
            r_err      <= 1'b0;
        end else begin
            r_err <= w_drop;
            if (w_iss_hs) begin
                r_rr_ptr <= (w_gnt_idx == LAST_IDX) ? '0 : w_gnt_idx + IDX_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_issue_vld && !fpu_issue_ready_i) begin
                        r_state    <= ST_LOCKED;
                        r_lock_idx <= w_rr_idx;
                    end
                end
                ST_LOCKED: begin
                    if (fpu_issue_ready_i) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // per-core outstanding counters; coincident issue and result on one core cancel out
    always_ff @(posedge clk_i) begin
        for (int c = 0; c < NB_CORES; c++) begin
            if (!rst_ni) begin
                r_outst[c] <= '0;
            end else begin
                if ((w_iss_hs && (w_gnt_idx == IDX_W'(c))) && !(w_res_hs && (w_dest_idx == IDX_W'(c)))) begin
                    r_outst[c] <= r_outst[c] + CNT_W'(1);
                end else if (!(w_iss_hs && (w_gnt_idx == IDX_W'(c))) && (w_res_hs && (w_dest_idx == IDX_W'(c)))) begin
                    r_outst[c] <= r_outst[c] - CNT_W'(1);
                end
            end
        end
    end

endmodule
